// File: rtl/decoder_pkg.sv
// Shared types for the sequenced binary-to-line decoder.
package decoder_pkg;

  // Output pattern selected per command.
  typedef enum logic [1:0] {
    ONEHOT  = 2'd0,
    THERMO  = 2'd1,
    WALK_UP = 2'd2,
    WALK_DN = 2'd3
  } dec_mode_t;

  // IDLE: nothing presented downstream. EMIT: a beat is on out_y.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } dec_state_t;

endpackage

// File: rtl/onehot_dec.sv
// Purely combinational N-bit index to 2**N-bit one-hot line decode.
module onehot_dec #(
  parameter int N = 3
) (
  input  logic [N-1:0]      idx,
  output logic [2**N-1:0]   y
);

  localparam int W = 2**N;

  // Single set bit at position idx.
  assign y = W'(1) << idx;

endmodule

// File: rtl/decoder_seq.sv
// Registered binary-to-line decoder with valid/ready on both sides.
// Modes: one-hot, thermometer, and multi-beat walking-one (up or down).
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_code,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**N-1:0]   out_y,
  output logic              out_last,
  output logic              busy
);

  localparam int W = 2**N;

  dec_state_t  state_q;
  dec_mode_t   mode_q;
  logic [N-1:0] code_q;
  logic [N-1:0] cnt_q;

  logic in_hs;
  logic out_hs;
  logic advance;

  // Source of the beat that will be registered at the next edge.
  dec_mode_t    sel_mode;
  logic [N-1:0] sel_code;
  logic [N-1:0] sel_cnt;
  logic [N-1:0] sel_idx;
  logic [W-1:0] onehot_y;
  logic [W-1:0] thermo_y;
  logic [W-1:0] next_y;
  logic         next_last;

  assign out_valid = (state_q == EMIT);
  assign busy      = out_valid;
  assign out_hs    = out_valid && out_ready;
  // A new command may load in the same edge that retires the last beat.
  assign in_ready  = (state_q == IDLE) || (out_hs && out_last);
  assign in_hs     = in_valid && in_ready;
  assign advance   = out_hs && !out_last;

  // Pick the fields describing the next beat: a fresh command or the next step of the current one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel_mode = mode_q;
    sel_code = code_q;
    sel_cnt  = cnt_q + 1'b1;
    if (in_hs) begin
      sel_mode = dec_mode_t'(in_mode);
      sel_code = in_code;
      sel_cnt  = '0;
    end
  end

  // Mode-dependent index into the shared one-hot decoder.
  always_comb begin
    sel_idx = sel_code;
    case (sel_mode)
      WALK_UP: sel_idx = sel_cnt;
      WALK_DN: sel_idx = sel_code - sel_cnt;
      default: sel_idx = sel_code;
    endcase
  end

  onehot_dec #(.N(N)) u_onehot (
    .idx (sel_idx),
    .y   (onehot_y)
  );

  // Thermometer is (onehot << 1) - 1 evaluated one bit wider so code W-1 gives all ones.
  assign thermo_y  = W'(({1'b0, onehot_y} << 1) - {{W{1'b0}}, 1'b1});
  assign next_y    = (sel_mode == THERMO) ? thermo_y : onehot_y;
  assign next_last = (sel_mode == ONEHOT) || (sel_mode == THERMO) || (sel_cnt == sel_code);

  // Command FSM plus registered beat outputs; stalled beats simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is a plain flop with a defined reset value; state uses non-blocking assignment only.
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= ONEHOT;
      code_q   <= '0;
      cnt_q    <= '0;
      out_y    <= '0;
      out_last <= 1'b0;
    end else if (in_hs) begin
      state_q  <= EMIT;
      mode_q   <= dec_mode_t'(in_mode);
      code_q   <= in_code;
      cnt_q    <= '0;
      out_y    <= next_y;
      out_last <= next_last;
    end else if (advance) begin
      cnt_q    <= sel_cnt;
      out_y    <= next_y;
      out_last <= next_last;
    end else if (out_hs) begin
      // Last beat taken with no follow-on command.
      state_q  <= IDLE;
      cnt_q    <= '0;
      out_y    <= '0;
      out_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: accepted commands expand into expected beats,
// a separate monitor compares every presented beat against the queue head.
module tb_decoder_seq;
  import decoder_pkg::*;

  localparam int N = 3;
  localparam int W = 1 << N;

  typedef struct {
    logic [W-1:0] y;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_code = '0;
  logic [1:0]   in_mode = 2'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_y;
  logic         out_last;
  logic         busy;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];

  decoder_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: expand a command into its beat list directly from the mode rules.
  task automatic push_cmd(input int code, input int mode);
    beat_t b;
    case (mode)
      0: begin b.y = W'(1 << code); b.last = 1'b1; exp_q.push_back(b); end
      1: begin b.y = W'((1 << (code + 1)) - 1); b.last = 1'b1; exp_q.push_back(b); end
      2: for (int k = 0; k <= code; k++) begin
           b.y = W'(1 << k); b.last = (k == code); exp_q.push_back(b);
         end
      default: for (int k = 0; k <= code; k++) begin
           b.y = W'(1 << (code - k)); b.last = (code - k == 0); exp_q.push_back(b);
         end
    endcase
  endtask

  task automatic cyc(input logic v, input int code, input int mode, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_code   = N'(code);
    in_mode   = 2'(mode);
    out_ready = r;
  endtask

  // Acceptance tracker: a command seen with in_valid && in_ready mid-cycle loads at the next edge.
  always @(negedge clk) begin
    #1;
    if (rst_n && in_valid && in_ready) push_cmd(int'(in_code), int'(in_mode));
  end

  // Monitor: compare whatever the DUT presents against the expected-beat queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_y", out_y, 0);
      check("rst_in_ready", in_ready, 1);
    end else begin
      check("out_valid", out_valid, exp_q.size() != 0);
      check("busy", busy, exp_q.size() != 0);
      if (exp_q.size() != 0 && out_valid) begin
        check("out_y", out_y, exp_q[0].y);
        check("out_last", out_last, exp_q[0].last);
        check("in_ready_emit", in_ready, out_ready && exp_q[0].last);
        if (out_ready) void'(exp_q.pop_front());
      end else if (!out_valid) begin
        check("idle_out_y", out_y, 0);
        check("idle_in_ready", in_ready, 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // One-hot code 5, single beat then idle.
    cyc(1, 5, 0, 1);
    cyc(0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 1);

    // Thermometer back-to-back.
    cyc(1, 0, 1, 1);
    cyc(1, 3, 1, 1);
    cyc(1, 7, 1, 1);
    repeat (2) cyc(0, 0, 0, 1);

    // Walk up code 7 with toggling out_ready; changing inputs while not ready are ignored.
    cyc(1, 7, 2, 1);
    for (int i = 0; i < 16; i++) cyc(0, $urandom_range(0, 7), 0, (i % 2) == 1);
    for (int i = 0; i < 4; i++) cyc(1, $urandom_range(0, 6), 1, 0);
    repeat (4) cyc(0, 0, 0, 1);
    cyc(1, 4, 2, 1);
    for (int i = 0; i < 4; i++) cyc(1, $urandom_range(0, 7), 3, 1);
    repeat (6) cyc(0, 0, 0, 1);

    // Walk down code 2 followed by zero-bubble one-hot code 0.
    cyc(1, 2, 3, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 1);

    // Reset during beat 3 of walk up code 6.
    cyc(1, 6, 2, 1);
    repeat (3) cyc(0, 0, 0, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out_y", out_y, 0);
    check("async_out_last", out_last, 0);
    check("async_busy", busy, 0);
    check("async_in_ready", in_ready, 1);
    exp_q.delete();
    repeat (2) cyc(1, 7, 2, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_code = 3'd3; in_mode = 2'd1; out_ready = 1'b1;
    repeat (4) cyc(0, 0, 0, 1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 4) != 0, $urandom_range(0, 7), $urandom_range(0, 3), ($urandom % 3) != 0);

    // Drain with a bounded wait.
    cyc(0, 0, 0, 1);
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      cyc(0, 0, 0, 1);
      budget++;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (2) cyc(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
